// File: rtl/key_input_scan_if.sv
// Key bundle between the raw push-button pins and the debounced event consumers.
// Ports: key_n (raw, active-low) plus key_state/key_press/key_release/key_long.
// master drives key_n and observes the events; slave is the scanner side.
interface key_input_scan_if #(
  parameter int N_KEYS = 4
);
  logic [N_KEYS-1:0] key_n;        // raw buttons, asynchronous, 0 = pressed
  logic [N_KEYS-1:0] key_state;    // debounced level, 1 = pressed
  logic [N_KEYS-1:0] key_press;    // one-cycle pulse on 0->1 of key_state
  logic [N_KEYS-1:0] key_release;  // one-cycle pulse on 1->0 of key_state
  logic [N_KEYS-1:0] key_long;     // one-cycle pulse once a press is held LONG_CYCLES

  modport master (
    output key_n,
    input  key_state,
    input  key_press,
    input  key_release,
    input  key_long
  );

  modport slave (
    input  key_n,
    output key_state,
    output key_press,
    output key_release,
    output key_long
  );
endinterface

// File: rtl/key_input_scan.sv
// Push-button scanner: 2-flop sync, per-key debounce, press/release/long-press pulses.
// Latency: key_n settled before edge k -> key_state/key_press at edge k+1+DB_CYCLES;
//   key_long at edge k+1+DB_CYCLES+LONG_CYCLES. No backpressure: pulses are fire-and-forget.
// Ports: clk, rst_n (async, active-low), kif (slave side of key_input_scan_if).
// DB_CYCLES must be >= 2 and LONG_CYCLES must exceed DB_CYCLES.
module key_input_scan #(
  parameter int N_KEYS      = 4,
  parameter int DB_CYCLES   = 1_000_000,
  parameter int LONG_CYCLES = 100_000_000
) (
  input  logic            clk,
  input  logic            rst_n,
  key_input_scan_if.slave kif
);

  localparam int DBW = $clog2(DB_CYCLES);
  localparam int HW  = $clog2(LONG_CYCLES + 1);

  localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
  localparam logic [HW-1:0]  HOLD_MAX  = HW'(LONG_CYCLES);
  localparam logic [HW-1:0]  HOLD_PRE  = HW'(LONG_CYCLES - 1);

  logic [N_KEYS-1:0] s1;
  logic [N_KEYS-1:0] s2;
  logic [N_KEYS-1:0] state_q;
  logic [N_KEYS-1:0] press_q;
  logic [N_KEYS-1:0] rel_q;
  logic [N_KEYS-1:0] long_q;
  logic [DBW-1:0]    db_cnt   [N_KEYS];
  logic [HW-1:0]     hold_cnt [N_KEYS];

  logic [N_KEYS-1:0] smp;
  logic [N_KEYS-1:0] tog;

  // smp is the synchronised sample in pressed-high polarity; tog marks the edge
  // at which the debounced level flips (disagreement has lasted DB_CYCLES cycles).
  always_comb begin
    smp = ~s2;
    tog = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      tog[i] = (smp[i] != state_q[i]) && (db_cnt[i] == DB_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1      <= '1;
      s2      <= '1;
      state_q <= '0;
      press_q <= '0;
      rel_q   <= '0;
      long_q  <= '0;
      for (int i = 0; i < N_KEYS; i++) begin
        db_cnt[i]   <= '0;
        hold_cnt[i] <= '0;
      end
    end else begin
      s1 <= kif.key_n;
      s2 <= s1;
      for (int i = 0; i < N_KEYS; i++) begin
        // Debounce: any agreeing sample restarts the count.
        if (smp[i] == state_q[i]) begin
          db_cnt[i] <= '0;
        end else if (tog[i]) begin
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DBW'(1);
        end

        if (tog[i]) begin
          state_q[i] <= ~state_q[i];
        end
        // Event pulses land on the same edge as the level change.
        press_q[i] <= tog[i] & ~state_q[i];
        rel_q[i]   <= tog[i] &  state_q[i];

        // Hold counter: idle while released, cleared on the release edge,
        // saturates so the long pulse can only fire once per press.
        if (!state_q[i] || tog[i]) begin
          hold_cnt[i] <= '0;
        end else if (hold_cnt[i] != HOLD_MAX) begin
          hold_cnt[i] <= hold_cnt[i] + HW'(1);
        end
        long_q[i] <= state_q[i] & ~tog[i] & (hold_cnt[i] == HOLD_PRE);
      end
    end
  end

  assign kif.key_state   = state_q;
  assign kif.key_press   = press_q;
  assign kif.key_release = rel_q;
  assign kif.key_long    = long_q;

endmodule

// File: doc/key_input_scan.md
Name: key_input_scan

Overview:
- Input-side counterpart to the board's LED output path. It samples four active-low push-buttons, synchronises and debounces each one, and produces a clean level plus single-cycle press, release and long-press event pulses.
- It sits directly below `top`, next to the LED driver.
- Clock and reset are shared with the rest of `top`: `clk` runs at 100 MHz, and `rst_n` is asynchronous, active-low.

Parameters:
- N_KEYS, 4, number of independent key channels.
- DB_CYCLES, 1_000_000, consecutive stable cycles needed to accept a level change (10 ms at 100 MHz). Must be ≥ 2.
- LONG_CYCLES, 100_000_000, cycles a debounced press must be held to raise `key_long` (1 s). Must be > DB_CYCLES.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- key_n  in  N_KEYS  raw button inputs, asynchronous, 0 = pressed.
- key_state  out  N_KEYS  debounced level, 1 = pressed.
- key_press  out  N_KEYS  one-cycle pulse when `key_state` bit goes 0→1.
- key_release  out  N_KEYS  one-cycle pulse when `key_state` bit goes 1→0.
- key_long  out  N_KEYS  one-cycle pulse after a press has been held LONG_CYCLES cycles.

Behaviour:
- Per-key channels are fully independent. Simultaneous activity on several keys is handled in parallel with no interaction.
- Reset, asynchronous while `rst_n` = 0:
  - Sync flops are set to 1 (released).
  - Debounce and hold counters are cleared.
  - `key_state`, `key_press`, `key_release` and `key_long` are all 0.
  - No pulse may be emitted on reset assertion or deassertion.
- Synchroniser: two flops, `s1` ← `~` not applied; `s1` ← `key_n`, then `s2` ← `s1`. The sample is `smp = ~s2` (1 = pressed).
- Debounce counter:
  - Width is `$clog2(DB_CYCLES)`.
  - When `smp == key_state`, the counter is cleared to 0.
  - When `smp != key_state` and counter < DB_CYCLES-1, the counter increments.
  - When `smp != key_state` and counter == DB_CYCLES-1, `key_state` toggles and the counter clears.
  - Any agreeing sample restarts the count, so a glitch of ≤ DB_CYCLES-1 synchronised cycles is ignored.
- Latency: if `key_n` settles low before rising edge k, `key_state` rises at edge k+1+DB_CYCLES. Release is symmetric.
- Event pulses:
  - `key_press` and `key_release` are registered at the same edge as the `key_state` change, so each is high for exactly the first cycle of the new level.
- Hold counter:
  - Width is `$clog2(LONG_CYCLES+1)`.
  - Held at 0 while `key_state` = 0.
  - Increments every cycle while `key_state` = 1, saturating at LONG_CYCLES.
  - `key_long` pulses for one cycle at the edge where the counter moves from LONG_CYCLES-1 to LONG_CYCLES, i.e. edge k+1+DB_CYCLES+LONG_CYCLES for the press above.
  - There is at most one `key_long` pulse per press.
  - The counter clears on the release edge. A release before LONG_CYCLES yields no `key_long`.
  - `key_release` is still emitted after a long press.
- Reset mid-operation: counters and outputs clear immediately and all pending pulses are dropped. A key still held after deassertion is re-detected as a fresh press 2+DB_CYCLES edges after deassertion.
- No combinational path from `key_n` to any output.

Test Plan (DB_CYCLES=8, LONG_CYCLES=32, PERIOD=10 ns, `rst_n` released at 20 ns):
- Clean press: drive `key_n[0]`=0 before edge k and hold it → `key_state[0]` rises at edge k+9, `key_press[0]` is high for 1 cycle there, and all other bits stay 0.
- Glitch reject: pulse `key_n[1]` low for 7 cycles, then high → `key_state[1]` stays 0 and no pulses appear. Repeat with an 8-cycle pulse → exactly one press, followed by one release 9 cycles after the return high.
- Bounce: toggle `key_n[2]` every 3 cycles for 30 cycles, then hold it low → exactly one `key_press[2]`, 9 edges after the final settle.
- Long press: hold `key_n[3]` low → `key_press[3]` at edge k+9, `key_long[3]` at edge k+41 and never again. On release, one `key_release[3]`.
- Simultaneous: press keys 0 and 2 on the same edge, with key 0 released after 20 cycles → both press pulses arrive on the same cycle. `key_long` fires only for key 2, and key 0 gives release with no long pulse.
- Reset mid-hold: assert `rst_n`=0 while key 0 has been held 20 cycles past its press → all outputs read 0 asynchronously. After deassertion with the key still held, a new `key_press[0]` appears 10 edges later.
